// File: rtl/encoder_4x2_pkg.sv
// Shared types and widths for the 4-to-2 handshake encoder.
package encoder_4x2_pkg;
  localparam int IDX_W = 2;
  localparam int REQ_W = 4;

  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/encoder_4x2_handshake_priority_select_4.sv
// Combinational priority pick over four request bits; direction set by HIGH_FIRST.
module priority_select_4
  import encoder_4x2_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [REQ_W-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from lowest to highest priority so the last match is the winner.
  always_comb begin
    idx = '0;
    any = |req;
    if (HIGH_FIRST) begin
      for (int i = 0; i < REQ_W; i++) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = REQ_W - 1; i >= 0; i--) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_4x2_handshake.sv
// Registered 4-to-2 priority encoder: latches requests, grants one index at a time,
// and clears it on ack. State table: IDLE | no grant, V=0 ; GRANT | A held, waiting ack.
module encoder_4x2_handshake
  import encoder_4x2_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic [REQ_W-1:0] D,
  input  logic             ack,
  output logic [IDX_W-1:0] A,
  output logic             V,
  output logic [REQ_W-1:0] pending
);

  state_t           state;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [REQ_W-1:0] clr;
  logic [REQ_W-1:0] set;

  priority_select_4 #(.HIGH_FIRST(HIGH_FIRST)) u_sel (
    .req (pending),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_comb begin
    clr = '0;
    if (V && ack) clr = REQ_W'(1) << A;
    set = E ? D : '0;
  end

  // Set is OR-ed after the clear so a same-cycle re-request survives the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      A       <= '0;
      V       <= 1'b0;
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | set;
      case (state)
        IDLE: begin
          if (sel_any) begin
            A     <= sel_idx;
            V     <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (ack) begin
            V     <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          V     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_4x2_handshake.sv
// Scoreboard bench: two encoders (high-first and low-first) share one stimulus stream.
module tb_encoder_4x2_handshake;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       E = 1'b0;
  logic [3:0] D = 4'b0000;
  logic       ack = 1'b0;
  logic [1:0] a_hi, a_lo;
  logic       v_hi, v_lo;
  logic [3:0] pend_hi, pend_lo;

  int tests = 0;
  int fails = 0;

  // Reference state per instance: 0 = high-first, 1 = low-first.
  bit [3:0] m_pend [2];
  bit       m_v    [2];
  int       m_a    [2];
  int       q_hi[$], q_lo[$];
  int       log_hi[$], log_lo[$];
  bit       vp_hi = 1'b0, vp_lo = 1'b0;

  encoder_4x2_handshake #(.HIGH_FIRST(1'b1)) u_hi (
    .clk(clk), .rst(rst), .E(E), .D(D), .ack(ack),
    .A(a_hi), .V(v_hi), .pending(pend_hi)
  );

  encoder_4x2_handshake #(.HIGH_FIRST(1'b0)) u_lo (
    .clk(clk), .rst(rst), .E(E), .D(D), .ack(ack),
    .A(a_lo), .V(v_lo), .pending(pend_lo)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic int prio(input bit [3:0] p, input bit hf);
    if (hf) begin
      for (int i = 3; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int i = 0; i < 4; i++) if (p[i]) return i;
    end
    return -1;
  endfunction

  // Advance the reference by one clock edge using the inputs about to be sampled.
  task automatic step(input int k);
    bit [3:0] clr;
    bit [3:0] nxt;
    int       p;
    if (rst) begin
      m_pend[k] = 4'b0000;
      m_v[k]    = 1'b0;
      m_a[k]    = 0;
      return;
    end
    clr = 4'b0000;
    if (m_v[k] && ack) clr[m_a[k]] = 1'b1;
    nxt = (m_pend[k] & ~clr) | (E ? D : 4'b0000);
    if (!m_v[k]) begin
      p = prio(m_pend[k], k == 0);
      if (p >= 0) begin
        m_v[k] = 1'b1;
        m_a[k] = p;
        if (k == 0) q_hi.push_back(p);
        else        q_lo.push_back(p);
      end
    end else if (ack) begin
      m_v[k] = 1'b0;
    end
    m_pend[k] = nxt;
  endtask

  task automatic cyc(input bit e, input bit [3:0] d, input bit a, input bit r);
    @(negedge clk);
    E = e; D = d; ack = a; rst = r;
    step(0);
    step(1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_log(input string name, input int got[$], input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, got[i], exp[i]);
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each new grant.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      chk("V_hi", v_hi, m_v[0]);
      chk("V_lo", v_lo, m_v[1]);
      chk("pending_hi", pend_hi, m_pend[0]);
      chk("pending_lo", pend_lo, m_pend[1]);
      if (v_hi && !vp_hi) begin
        if (q_hi.size() == 0) chk("grant_hi_unexpected", 1, 0);
        else begin
          e = q_hi.pop_front();
          chk("A_hi", a_hi, e);
          log_hi.push_back(int'(a_hi));
        end
      end
      if (v_lo && !vp_lo) begin
        if (q_lo.size() == 0) chk("grant_lo_unexpected", 1, 0);
        else begin
          e = q_lo.pop_front();
          chk("A_lo", a_lo, e);
          log_lo.push_back(int'(a_lo));
        end
      end
      vp_hi = v_hi;
      vp_lo = v_lo;
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 4'b0000; m_v[k] = 1'b0; m_a[k] = 0;
    end

    // Reset then idle
    cyc(1, 4'b1111, 0, 1);
    cyc(1, 4'b1111, 0, 1);
    after_edge();
    chk("rst_pending", pend_hi, 0);
    chk("rst_V", v_hi, 0);
    chk("rst_A", a_hi, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4'b1111, 0, 0);
    after_edge();
    chk("disabled_pending", pend_hi, 0);
    chk("disabled_V", v_hi, 0);

    // Single request
    cyc(1, 4'b0100, 0, 0);
    after_edge();
    chk("single_pending", pend_hi, 4'b0100);
    chk("single_V_early", v_hi, 0);
    cyc(0, 4'b0000, 0, 0);
    after_edge();
    chk("single_V", v_hi, 1);
    chk("single_A", a_hi, 2);
    cyc(0, 4'b0000, 1, 0);
    after_edge();
    chk("single_ack_V", v_hi, 0);
    chk("single_ack_pending", pend_hi, 0);
    cyc(0, 4'b0000, 0, 0);

    // Priority order with ack held high
    log_hi.delete(); log_lo.delete();
    cyc(1, 4'b1011, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 4'b0000, 1, 0);
    after_edge();
    chk_log("order_hi", log_hi, '{3, 1, 0});
    chk_log("order_lo", log_lo, '{0, 1, 3});

    // No preemption
    log_hi.delete();
    cyc(1, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    cyc(1, 4'b1000, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    after_edge();
    chk("nopreempt_A", a_hi, 1);
    cyc(0, 4'b0000, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 1, 0);
    after_edge();
    chk_log("nopreempt_hi", log_hi, '{1, 3});

    // Set wins over clear
    log_hi.delete();
    cyc(1, 4'b0100, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    cyc(1, 4'b0100, 1, 0);
    after_edge();
    chk("setwins_pending2", pend_hi[2], 1);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1, 0);
    after_edge();
    chk_log("setwins_hi", log_hi, '{2, 2});

    // Reset mid-grant
    log_hi.delete();
    cyc(1, 4'b1010, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    after_edge();
    chk("midgrant_V", v_hi, 1);
    chk("midgrant_pending", pend_hi, 4'b1010);
    cyc(0, 4'b0000, 0, 1);
    after_edge();
    chk("midrst_V", v_hi, 0);
    chk("midrst_A", a_hi, 0);
    chk("midrst_pending", pend_hi, 0);
    log_hi.delete();
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 1, 0);
    after_edge();
    chk("midrst_no_grant", log_hi.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end
    cyc(0, 4'b0000, 0, 0);
    after_edge();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/encoder_4x2_handshake.md
# encoder_4x2_handshake

Registered 4-to-2 priority encoder with request latching and a valid/acknowledge handshake. It is the inverse of the team's enabled 2x4 decoder: it turns up to four one-hot-style request lines into a 2-bit index. Pending requests are held until a consumer acknowledges them, one at a time, highest priority first. It sits between request sources (e.g. a decoder's outputs or interrupt lines) and a single consumer that services one index at a time.

## Interface
- HIGH_FIRST, default 1: 1 = D[3] has highest priority; 0 = D[0] has highest priority.

- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- E  input  1  enable; when 0, new requests on D are not latched
- D  input  4  request lines, sampled every edge while E=1
- ack  input  1  consumer acknowledge of the index currently on A
- A  output  2  encoded index of the granted request; registered
- V  output  1  A is valid; registered
- pending  output  4  latched, not-yet-acknowledged requests; registered

## Operation
- Pending register update, every edge: pending <= (pending & ~clr) | (E ? D : 4'b0000).
  - clr = one-hot(A) when V=1 and ack=1; otherwise 0.
  - Set wins over clear: a request re-asserted on the same bit in the acknowledging cycle stays pending.
- State machine, two states:
  - IDLE: V=0. If pending != 0 at the edge, load A with the priority index of the registered pending value, set V=1, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: V=1 and A held stable. If ack=1 at the edge, clear that pending bit, set V=0, and go to IDLE. Otherwise stay in GRANT.
- Priority is evaluated only on the IDLE->GRANT transition. A higher-priority request arriving during GRANT does not preempt; it is served after the current ack.
- ack while V=0 is ignored and has no effect on pending.
- E=0 blocks new latching only. Already-pending requests continue to be granted and acknowledged.
- Reset: pending=4'b0000, A=2'b00, V=0, state=IDLE. Reset mid-GRANT drops all pending requests and the current grant.

## Timing
- Request latency: D asserted (E=1) before edge t -> pending bit set after edge t -> A/V valid after edge t+1, i.e. 2 cycles.
- Ack sampled at edge k with V=1 -> V=0 and the pending bit cleared after edge k.
- Earliest next grant is after edge k+1, so there is at least one V=0 cycle between grants.
- A changes only on the IDLE->GRANT edge. A resets to 0 but is don't-care while V=0.
- Throughput: at most one grant per 2 cycles with ack tied high.

## Structure
- Package encoder_4x2_pkg holds:
  - the state enum {IDLE, GRANT};
  - the index width constant (2);
  - the request width constant (4).
- Sub-module priority_select_4: purely combinational. Inputs are req[3:0] and the HIGH_FIRST parameter; outputs are idx[1:0] and any. The top instantiates it once on the registered pending value.

## Test plan
- Reset then idle: rst=1 for 2 cycles, D=4'b1111 -> pending=0, V=0, A=0. After release with E=0 and D=4'b1111, pending stays 0 and V stays 0.
- Single request: E=1, D=4'b0100 for one cycle -> pending=4'b0100 after 1 edge; A=2'b10, V=1 after 2 edges. ack=1 for one cycle -> V=0, pending=0.
- Priority order: E=1, D=4'b1011 for one cycle, ack held 1.
  - HIGH_FIRST=1: A sequence 3,1,0, each grant separated by one V=0 cycle.
  - HIGH_FIRST=0: A sequence 0,1,3.
- No preemption: grant A=2'b01 active, then D=4'b1000 arrives -> A stays 01 until ack, then A=11 on the next grant.
- Set-wins collision: grant A=2'b10 with ack=1 and D=4'b0100 in the same cycle -> pending[2] remains 1, and the next grant is again A=10.
- Reset mid-grant: V=1, pending=4'b1010, rst=1 for one cycle -> V=0, A=0, pending=0, state IDLE. With no new requests, no grant follows.
